// File: rtl/nf_reg_file_gen_if.sv
// Register file access bundle: two read ports, one scan port, one write port,
// plus the busy indication raised while the post-reset clear sequence runs.
//   master : drives read/scan/write addresses and write data/enable
//   slave  : returns read data and busy
interface nf_reg_file_gen_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    logic [AW-1:0]   ra1;
    logic [XLEN-1:0] rd1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] rd2;
    logic [AW-1:0]   ra0;
    logic [XLEN-1:0] rd0;
    logic [AW-1:0]   wa3;
    logic [XLEN-1:0] wd3;
    logic            we3;
    logic            busy;

    modport master (
        output ra1, ra2, ra0, wa3, wd3, we3,
        input  rd1, rd2, rd0, busy
    );

    modport slave (
        input  ra1, ra2, ra0, wa3, wd3, we3,
        output rd1, rd2, rd0, busy
    );
endinterface

// File: rtl/nf_reg_file_gen.sv
// Parametrised general-purpose register file for the nanoFOX core.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, starts the clear sequence
//   rf   : nf_reg_file_gen_if slave (ra1/rd1, ra2/rd2, ra0/rd0 scan,
//          wa3/wd3/we3 write, busy while clearing)
// Read data is combinational. rd1/rd2 may forward same-cycle write data
// (BYPASS=1); rd0 always shows stored contents. After reset every register
// is zeroed, one per cycle, while busy holds the core off.
module nf_reg_file_gen #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    nf_reg_file_gen_if.slave   rf
);

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   cnt_q;
    logic [AW-1:0]   cnt_d;
    logic            clr_we_c;
    logic            wr_acc_c;
    logic            busy_c;

    // Storage deliberately has no reset; the sequencer zeroes it.
    logic [XLEN-1:0] mem [DEPTH];

    // Address lies inside the populated part of the address space.
    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    // Address is the hardwired zero register.
    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear sequencer: next state and clear-write strobe.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        clr_we_c = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we_c = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign busy_c   = (state_q == CLEAR);
    assign wr_acc_c = !busy_c && rf.we3 && in_range(rf.wa3) && !is_zero_reg(rf.wa3);

    // Storage write: the sequencer owns the array during CLEAR, so external
    // writes cannot collide with it. Nothing is written on a reset edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we_c) begin
                mem[cnt_q] <= '0;
            end else if (wr_acc_c) begin
                mem[rf.wa3] <= rf.wd3;
            end
        end
    end

    // Read priority: busy, out of range, zero register, bypass, storage.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a,
                                                  input logic          byp_en);
        logic [XLEN-1:0] r;
        r = '0;
        if (busy_c || !in_range(a) || is_zero_reg(a)) begin
            r = '0;
        end else if (byp_en && BYPASS && wr_acc_c && (rf.wa3 == a)) begin
            r = rf.wd3;
        end else begin
            r = mem[a];
        end
        return r;
    endfunction

    assign rf.rd1  = read_port(rf.ra1, 1'b1);
    assign rf.rd2  = read_port(rf.ra2, 1'b1);
    assign rf.rd0  = read_port(rf.ra0, 1'b0);
    assign rf.busy = busy_c;

endmodule
